// File: rtl/aes_dec_round_ctrl.sv
// aes_dec_round_ctrl: iterative AES decryption round sequencer
// Owns the 128-bit state register and round counter, drives one shared
// inverse-round datapath and the round-key store read index.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     ciphertext handshake, in_data block
//   rk_idx/rk_data        round-key store index and same-cycle key
//   dp_state/dp_last      datapath operand and InvMixColumns bypass
//   dp_result             combinational datapath result
//   out_valid/out_ready   plaintext handshake, out_data block
//   busy                  high whenever not IDLE
//   abort                 only when AES_DEC_CTRL_ABORT_EN is defined
module aes_dec_round_ctrl #(
  parameter int NR  = 10,
  parameter int KIW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
`ifdef AES_DEC_CTRL_ABORT_EN
  input  logic           abort,
`endif
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_data,
  output logic [KIW-1:0] rk_idx,
  input  logic [127:0]   rk_data,
  output logic [127:0]   dp_state,
  output logic           dp_last,
  input  logic [127:0]   dp_result,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_data,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} st_t;
  localparam logic [KIW-1:0] KNR  = KIW'(NR);
  localparam logic [KIW-1:0] KNR1 = KIW'(NR - 1);
  st_t st, st_n;
  logic [127:0] state, state_n;
  logic [KIW-1:0] cnt, cnt_n;
  logic kill;
`ifdef AES_DEC_CTRL_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= IDLE;
      state <= '0;
      cnt   <= '0;
    end else begin
      st    <= st_n;
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    st_n    = st;
    state_n = state;
    cnt_n   = cnt;
    case (st)
      IDLE:
        if (in_valid && !kill) begin
          state_n = in_data ^ rk_data;
          cnt_n   = KNR1;
          st_n    = ROUND;
        end
      ROUND: begin
        state_n = dp_result;
        // exit is decided on the zero count, so the counter never wraps
        if (cnt == '0) st_n = DONE;
        else cnt_n = cnt - KIW'(1);
      end
      DONE:
        if (out_ready) st_n = IDLE;
      default: st_n = IDLE;
    endcase
    // abort outranks both completion and a new accept
    if (kill && st != IDLE) begin
      st_n    = IDLE;
      state_n = '0;
      cnt_n   = '0;
    end
  end
  assign in_ready  = st == IDLE;
  assign busy      = st != IDLE;
  assign out_valid = st == DONE;
  assign dp_last   = st == ROUND && cnt == '0;
  assign rk_idx    = st == ROUND ? cnt : KNR;
  assign dp_state  = state;
  assign out_data  = state;
endmodule

// File: doc/aes_dec_round_ctrl.md
Name: aes_dec_round_ctrl

Overview:
- Iterative AES decryption round sequencer. Owns the 128-bit state register and the round counter.
- Drives one shared combinational inverse-round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey -> invmixcolumns, with InvMixColumns bypassable.
- Drives the read index of the external round-key store.
- Sits between the block-input valid/ready interface and the block-output valid/ready interface of the AES_dec core.

Parameters:
- NR, 10: number of rounds (10/12/14 for AES-128/192/256); sets the initial counter and key index.
- KIW, 4: width of rk_idx; must satisfy 2^KIW > NR.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ciphertext block valid.
- in_ready  out  1  controller can accept a block.
- in_data  in  128  ciphertext block.
- rk_idx  out  KIW  round-key index to key store.
- rk_data  in  128  round key for rk_idx; combinational, same-cycle read.
- dp_state  out  128  current state to datapath; equals the state register.
- dp_last  out  1  datapath must bypass InvMixColumns (final round).
- dp_result  in  128  combinational datapath result for dp_state/rk_data/dp_last.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  downstream accepts plaintext.
- out_data  out  128  plaintext; equals the state register.
- busy  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, rst_n=0) takes effect immediately, with no clock edge:
  - FSM=IDLE, state register=0, counter=0.
  - out_valid=0, dp_last=0, busy=0, in_ready=1, rk_idx=NR.
- States: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1, rk_idx=NR.
  - On edge with in_valid=1: state <= in_data ^ rk_data (initial AddRoundKey), counter <= NR-1, go to ROUND.
- ROUND:
  - in_ready=0, rk_idx=counter, dp_last=(counter==0).
  - Each edge: state <= dp_result.
  - If counter!=0: counter <= counter-1, stay in ROUND. If counter==0: go to DONE.
- DONE:
  - out_valid=1, rk_idx=NR, in_ready=0.
  - On edge with out_ready=1: go to IDLE, out_valid drops next cycle.
  - While out_ready=0: out_data and out_valid held stable indefinitely.
- Timing: out_valid rises exactly NR clocks after the accepting edge. Minimum block-to-block interval is NR+2 clocks. No overlap between blocks.
- rk_idx sequence per block: NR (accept), NR-1, ..., 1, 0.
- dp_last is high for exactly one cycle per block, and only while rk_idx==0.
- in_valid while busy is ignored. The block is not consumed, and the upstream source must hold it until in_ready=1.
- out_ready while out_valid=0 is ignored.
- Async reset mid-ROUND or mid-DONE: the block is discarded, no out_valid is produced, and the next block is accepted normally after release.
- Counter never wraps: the ROUND exit is decided at counter==0, before any decrement.
- All widths are fixed at 128. The XOR in IDLE is bitwise with no carry.

Optional Feature:
- Macro: AES_DEC_CTRL_ABORT_EN.
- Defined:
  - Adds input abort (1 bit).
  - abort=1 at an edge in ROUND or DONE forces IDLE and clears the state register to 0. out_valid=0 from the next cycle.
  - abort in IDLE has priority over in_valid: the block is not accepted.
  - Async reset still dominates.
- Undefined: no abort port. The FSM can leave ROUND/DONE only by completion or reset.

Test Plan:
- Reset values: hold rst_n=0 -> in_ready=1, out_valid=0, busy=0, rk_idx=10, out_data=0. Assert rst_n low asynchronously between edges -> outputs change before the next edge.
- FIPS-197 AES-128 single block: in_data=69c4e0d86a7b0430d8cdb78070b4c55a, key 000102030405060708090a0b0c0d0e0f, reference datapath + key-schedule models, out_ready=1 -> out_data=00112233445566778899aabbccddeeff. out_valid exactly 10 clocks after accept. rk_idx trace 10,9,...,0. dp_last high only on the rk_idx=0 cycle.
- Backpressure: same block, out_ready=0 for 5 cycles after out_valid -> out_data/out_valid stable. in_ready stays 0. Release -> IDLE next cycle.
- Busy input: second block presented at cycle 3 after the first accept, in_valid held -> not accepted until in_ready=1. Both plaintexts correct and in order. Interval between accepts equals 12 clocks.
- Reset mid-operation: rst_n low during ROUND with rk_idx=5 -> immediate IDLE, no out_valid. Then decrypt the FIPS vector correctly.
- (AES_DEC_CTRL_ABORT_EN) abort pulse at rk_idx=4 -> IDLE next cycle, state=0, no out_valid. abort together with in_valid in IDLE -> no accept.
